// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART.
package uart_pkg;

  localparam int unsigned CLK_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c,
  output logic                   empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Flags come from the registered count only, so a full FIFO never takes a write even if popped that cycle.
  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rdata_c = empty_c ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_buffered_io.sv
// 8N1 UART with FIFO-buffered transmit and receive paths and sticky error flags.
module uart_buffered_io
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rx,
  output logic                      tx,
  input  logic                      wen,
  input  logic [7:0]                wdata,
  output logic                      wready,
  input  logic                      ren,
  output logic [7:0]                rdata,
  output logic                      rvalid,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      overrun,
  output logic                      frame_err,
  input  logic                      err_clr
);
  localparam int unsigned BCW = $clog2(CLK_PER_BIT);

  tx_state_t        tx_state;
  logic [BCW-1:0]   tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;
  logic [7:0]       tx_head_c;
  logic             tx_full_c;
  logic             tx_empty_c;
  logic             tx_end_c;
  logic             tx_pop_c;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [BCW-1:0]   rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_full_c;
  logic             rx_empty_c;
  logic             rx_end_c;
  logic             rx_mid_c;
  logic             stop_smp_c;
  logic             rx_push_c;

  assign wready = !tx_full_c;
  assign rvalid = !rx_empty_c;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(wen), .wdata(wdata), .pop(tx_pop_c),
    .rdata_c(tx_head_c), .count(tx_count), .full_c(tx_full_c), .empty_c(tx_empty_c)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push_c), .wdata(rx_sh), .pop(ren),
    .rdata_c(rdata), .count(rx_count), .full_c(rx_full_c), .empty_c(rx_empty_c)
  );

  // A new byte is taken from idle, or straight from the end of a stop bit for gapless frames.
  assign tx_end_c = (tx_cnt == BCW'(CLK_PER_BIT - 1));
  assign tx_pop_c = !tx_empty_c &&
                    ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_end_c));

  // tx is registered from the state, so the line lags the state by one cycle uniformly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx     <= 1'b1;
          tx_cnt <= '0;
          if (tx_pop_c) begin
            tx_sh    <= tx_head_c;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          tx <= 1'b0;
          if (tx_end_c) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + BCW'(1);
          end
        end
        TX_DATA: begin
          tx <= tx_sh[0];
          if (tx_end_c) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + BCW'(1);
          end
        end
        default: begin
          tx <= 1'b1;
          if (tx_end_c) begin
            tx_cnt <= '0;
            if (tx_pop_c) begin
              tx_sh    <= tx_head_c;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + BCW'(1);
          end
        end
      endcase
    end
  end

  assign rx_end_c   = (rx_cnt == BCW'(CLK_PER_BIT - 1));
  assign rx_mid_c   = (rx_cnt == BCW'(CLK_PER_BIT / 2 - 1));
  assign stop_smp_c = (rx_state == RX_STOP) && rx_end_c;
  assign rx_push_c  = stop_smp_c && rx_s2 && !rx_full_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_mid_c) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + BCW'(1);
          end
        end
        RX_DATA: begin
          if (rx_end_c) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + BCW'(1);
          end
        end
        default: begin
          if (rx_end_c) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + BCW'(1);
          end
        end
      endcase
      // Sticky flags: a set in the same cycle as err_clr takes priority.
      if (stop_smp_c && rx_s2 && rx_full_c) overrun <= 1'b1;
      else if (err_clr)                     overrun <= 1'b0;
      if (stop_smp_c && !rx_s2) frame_err <= 1'b1;
      else if (err_clr)         frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_buffered_io.sv
// Randomized self-checking bench for uart_buffered_io against a queue-based reference model.
module tb_uart_buffered_io;
  localparam int unsigned CPB = 4;
  localparam int unsigned TXD = 4;
  localparam int unsigned RXD = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx;
  logic       tx;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       wready;
  logic       ren = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [2:0] tx_count;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       err_clr = 1'b0;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;

  assign rx = loop ? tx : rx_drv;

  uart_buffered_io #(.CLK_PER_BIT(CPB), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .tx(tx), .wen(wen), .wdata(wdata),
    .wready(wready), .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .tx_count(tx_count), .rx_count(rx_count), .overrun(overrun),
    .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected line waveform of one 8N1 frame, one entry per clock, start bit first.
  function automatic logic [39:0] frame_wave(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] w;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) w[k] = f[k / CPB];
    return w;
  endfunction

  logic       tx_hist [0:255];
  logic       wr_hist [0:255];
  logic [2:0] tc_hist [0:255];
  logic [7:0] burst [5];
  logic [7:0] rx_model [$];
  logic       m_ov;
  logic       m_fe;

  // Writes nb bytes on consecutive edges and checks the resulting line activity.
  task automatic tx_burst(input int nb, input string tag);
    int          first_rdy;
    logic [39:0] g;
    first_rdy = -1;
    @(posedge clk); #1;
    wen = 1'b1; wdata = burst[0];
    for (int i = 0; i < nb * 40 + 4; i++) begin
      @(posedge clk); #1;
      tx_hist[i] = tx; wr_hist[i] = wready; tc_hist[i] = tx_count;
      wen = (i + 1 < nb);
      if (i + 1 < nb) wdata = burst[i + 1];
    end
    check({tag, "_idle_n"}, 64'(tx_hist[0]), 64'd1);
    check({tag, "_idle_n1"}, 64'(tx_hist[1]), 64'd1);
    for (int f = 0; f < nb; f++) begin
      for (int k = 0; k < 40; k++) g[k] = tx_hist[2 + 40 * f + k];
      check({tag, "_frame"}, 64'(g), 64'(frame_wave(burst[f])));
    end
    check({tag, "_idle_end"}, 64'(tx_hist[2 + 40 * nb]), 64'd1);
    check({tag, "_txcount"}, 64'(tc_hist[nb - 1]), (nb == 1) ? 64'd1 : 64'(nb - 1));
    if (nb == 5) begin
      for (int i = 4; i < 200; i++)
        if (first_rdy < 0 && wr_hist[i]) first_rdy = i;
      check({tag, "_wready_low"}, 64'(wr_hist[4]), 64'd0);
      check({tag, "_wready_back"}, 64'(first_rdy), 64'd41);
    end
  endtask

  // Drives one frame onto rx from the bench and updates the receive model.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int j = 0; j < 10; j++) begin
      rx_drv = bits[j];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    if (!stop) m_fe = 1'b1;
    else if (rx_model.size() >= RXD) m_ov = 1'b1;
    else rx_model.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = rx_model.pop_front();
    check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    check({tag, "_rdata"}, 64'(rdata), 64'(e));
    ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_ov = 1'b0; m_fe = 1'b0;
  endtask

  task automatic wait_rvalid(input string tag);
    int n;
    n = 0;
    while (!rvalid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rvalid) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic write_byte(input logic [7:0] b, input string tag);
    int n;
    n = 0;
    while (!wready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wready) check({tag, "_wready_timeout"}, 64'd0, 64'd1);
    wen = 1'b1; wdata = b;
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  initial begin
    logic [7:0] lb [6];
    m_ov = 1'b0; m_fe = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_wready", 64'(wready), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'h00);
    check("rst_txcount", 64'(tx_count), 64'd0);
    check("rst_rxcount", 64'(rx_count), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    burst[0] = 8'hA5;
    tx_burst(1, "a5");

    for (int i = 0; i < 5; i++) burst[i] = 8'($urandom);
    tx_burst(5, "b2b");

    loop = 1'b1;
    write_byte(8'h3C, "loop3c");
    wait_rvalid("loop3c");
    check("loop3c_rvalid", 64'(rvalid), 64'd1);
    check("loop3c_rdata", 64'(rdata), 64'h3C);
    ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    check("loop3c_empty", 64'(rvalid), 64'd0);
    check("loop3c_rdata0", 64'(rdata), 64'h00);
    repeat (20) @(posedge clk);
    #1;
    loop = 1'b0;

    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    check("ovr_rxcount", 64'(rx_count), 64'(rx_model.size()));
    check("ovr_flag", 64'(overrun), 64'(m_ov));
    clear_errs();
    check("ovr_clr", 64'(overrun), 64'd0);
    while (rx_model.size() > 0) pop_check("ovr_pop");
    check("ovr_drained", 64'(rvalid), 64'd0);

    send_frame(8'h55, 1'b0);
    check("fe_flag", 64'(frame_err), 64'(m_fe));
    check("fe_rxcount", 64'(rx_count), 64'd0);
    clear_errs();
    check("fe_clr", 64'(frame_err), 64'd0);

    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("glitch_rxcount", 64'(rx_count), 64'd0);
    check("glitch_ferr", 64'(frame_err), 64'd0);
    check("glitch_ovr", 64'(overrun), 64'd0);

    for (int it = 0; it < 30; it++) begin
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0));
      check("rnd_rxcount", 64'(rx_count), 64'(rx_model.size()));
      if ($urandom_range(0, 3) == 0) begin
        check("rnd_ovr", 64'(overrun), 64'(m_ov));
        check("rnd_ferr", 64'(frame_err), 64'(m_fe));
        clear_errs();
      end
      if (rx_model.size() > 0 && $urandom_range(0, 1) == 1) pop_check("rnd_pop");
    end
    check("rnd_ovr_end", 64'(overrun), 64'(m_ov));
    check("rnd_ferr_end", 64'(frame_err), 64'(m_fe));
    while (rx_model.size() > 0) pop_check("rnd_drain");
    clear_errs();

    loop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lb[i] = 8'($urandom);
      write_byte(lb[i], "rloop");
    end
    for (int i = 0; i < 6; i++) begin
      wait_rvalid("rloop");
      check("rloop_rdata", 64'(rdata), 64'(lb[i]));
      ren = 1'b1;
      @(posedge clk); #1;
      ren = 1'b0;
    end
    check("rloop_ovr", 64'(overrun), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    loop = 1'b0;

    send_frame(8'h81, 1'b1);
    rx_model.delete();
    wen = 1'b1; wdata = 8'hF0;
    @(posedge clk); #1;
    wdata = 8'h0F;
    @(posedge clk); #1;
    wen = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_tx", 64'(tx), 64'd1);
    check("mrst_txcount", 64'(tx_count), 64'd0);
    check("mrst_rxcount", 64'(rx_count), 64'd0);
    check("mrst_wready", 64'(wready), 64'd1);
    check("mrst_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    burst[0] = 8'($urandom);
    tx_burst(1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_buffered_io.md
UART_BUFFERED_IO -- requirements
Module: uart_buffered_io

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 4.
REQ-002 SHALL have parameter TX_DEPTH, default 16, TX FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter RX_DEPTH, default 16, RX FIFO entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rx  input  1  serial in, asynchronous to clk.
REQ-007 SHALL have port tx  output  1  serial out, 8N1, LSB first.
REQ-008 SHALL have port wen  input  1  push wdata into TX FIFO.
REQ-009 SHALL have port wdata  input  8  byte to transmit.
REQ-010 SHALL have port wready  output  1  TX FIFO not full.
REQ-011 SHALL have port ren  input  1  pop RX FIFO head.
REQ-012 SHALL have port rdata  output  8  RX FIFO head, first-word-fall-through.
REQ-013 SHALL have port rvalid  output  1  RX FIFO not empty.
REQ-014 SHALL have port tx_count  output  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
REQ-015 SHALL have port rx_count  output  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
REQ-016 SHALL have port overrun  output  1  sticky: received byte dropped, RX FIFO full.
REQ-017 SHALL have port frame_err  output  1  sticky: stop bit sampled 0.
REQ-018 SHALL have port err_clr  input  1  one-cycle clear of overrun and frame_err.

Function
REQ-019 Write accepted iff wen && wready; wen with wready=0 SHALL be ignored, no state change.
REQ-020 Pop iff ren && rvalid; ren with rvalid=0 SHALL be ignored; rdata SHALL be 8'h00 while rvalid=0.
REQ-021 Simultaneous push and pop on one FIFO SHALL leave its count unchanged; wready reflects registered count (no same-cycle full bypass).
REQ-022 TX FSM states TX_IDLE, TX_START, TX_DATA, TX_STOP; TX_IDLE->TX_START when TX FIFO non-empty, popping the byte that cycle.
REQ-023 Byte written at edge n into empty FIFO with idle TX SHALL drive tx=0 from edge n+2; each bit lasts exactly CLK_PER_BIT cycles; frame = 10 bits.
REQ-024 TX_STOP->TX_START directly if FIFO non-empty at end of stop bit (back-to-back frames, no idle gap); else ->TX_IDLE with tx=1.
REQ-025 rx SHALL pass a 2-flop synchroniser before use.
REQ-026 RX FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP; falling edge in RX_IDLE ->RX_START; start re-sampled at CLK_PER_BIT/2; if 1, glitch, ->RX_IDLE.
REQ-027 Data bits sampled at mid-bit, every CLK_PER_BIT cycles, LSB first; stop bit sampled at mid-bit.
REQ-028 Stop=1 and RX FIFO not full: byte pushed, rvalid rises 1 cycle after stop sample. Stop=1 and full: byte dropped, overrun<=1. Stop=0: byte dropped, frame_err<=1.
REQ-029 After stop sample RX FSM SHALL return to RX_IDLE and accept a new start edge immediately.
REQ-030 Set event and err_clr in the same cycle: set SHALL win.

Reset
REQ-031 Asserting rstn low SHALL immediately force: tx=1, wready=1, rvalid=0, rdata=8'h00, tx_count=0, rx_count=0, overrun=0, frame_err=0, both FSMs idle, FIFO pointers 0.
REQ-032 Reset mid-frame SHALL abort it; FIFO contents discarded; first frame after release is complete.

Structure
REQ-033 Package uart_pkg SHALL hold tx_state_t, rx_state_t enums and CLK_PER_BIT default constant.
REQ-034 Sub-module sync_fifo (parameters WIDTH, DEPTH; FWFT; count output) SHALL be instantiated twice: TX and RX.

Verification (CLK_PER_BIT=4, depths 4)
REQ-035 Write 8'hA5 once -> tx low at n+2, then bits 1,0,1,0,0,1,0,1, stop 1; 40 cycles total.
REQ-036 Write 5 bytes back-to-back, TX idle -> 5th accepted, then wready=0 holds until the first pop; 5 frames contiguous, no gap.
REQ-037 Loop tx->rx, send 8'h3C -> rvalid=1, rdata=8'h3C; ren -> rvalid=0, rdata=8'h00.
REQ-038 Inject 5 frames, no ren -> rx_count=4, overrun=1, first 4 bytes intact; err_clr -> overrun=0.
REQ-039 Inject frame 8'h55 with stop=0 -> frame_err=1, rx_count unchanged; 1-cycle rx glitch (2 clk) -> no byte, no error.
REQ-040 Assert rstn low mid-frame -> same-cycle tx=1, counts 0; next write transmits a clean frame.
